cond_logic: RTL and testbench
=============================

COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; flag register updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; clears flag register.
REQ-004 pcs  input  1  decoder request: write PC (branch or write to R15).
REQ-005 reg_w  input  1  decoder request: register-file write.
REQ-006 mem_w  input  1  decoder request: memory write.
REQ-007 no_write  input  1  suppress register write (compare-type ops).
REQ-008 flag_w  input  2  flag-update request; bit1 = {N,Z} group, bit0 = {C,V} group.
REQ-009 cond  input  4  instruction condition field.
REQ-010 alu_flags  input  4  ALU flags {N,Z,C,V}, bit3..bit0.
REQ-011 pc_src  output  1  gated PC write.
REQ-012 reg_write  output  1  gated register write.
REQ-013 mem_write  output  1  gated memory write.

Function
REQ-014 Internal 4-bit flag register flags = {n,z,c,v}; cond_ex evaluates against the registered flags, never directly against alu_flags.
REQ-015 cond_ex, combinational: 0000 EQ z; 0001 NE ~z; 0010 CS c; 0011 CC ~c; 0100 MI n; 0101 PL ~n; 0110 VS v; 0111 VC ~v; 1000 HI c&~z; 1001 LS ~c|z; 1010 GE n==v; 1011 LT n!=v; 1100 GT ~z&(n==v); 1101 LE z|(n!=v); 1110 AL 1; 1111 0 (never).
REQ-016 flag_write[1:0] = flag_w & {cond_ex,cond_ex}.
REQ-017 On rising clk: flag_write[1] -> flags[3:2] <= alu_flags[3:2]; flag_write[0] -> flags[1:0] <= alu_flags[1:0]; each group holds independently otherwise.
REQ-018 Flag update latency one cycle: flags written at edge k are first used by cond_ex after edge k.
REQ-019 cond_ex uses pre-edge flags in the cycle that writes them; the write itself is gated by that cond_ex.
REQ-020 pc_src = pcs & cond_ex, combinational.
REQ-021 reg_write = reg_w & cond_ex & ~no_write, combinational.
REQ-022 mem_write = mem_w & cond_ex, combinational.
REQ-023 Outputs have no registered stage; input changes propagate same cycle.
REQ-024 cond_ex, flag_write, flags observable as internal signals of those exact names for bench probing.

Reset
REQ-025 reset low clears flags to 0000 immediately, regardless of clk.
REQ-026 While reset low, flags held 0000; outputs remain combinational on inputs (e.g., cond=AL, pcs=1 -> pc_src=1).
REQ-027 Reset deasserted mid-operation: first flag update at the next rising edge with flag_write nonzero.

Structure
REQ-028 Shared package holds condition-code constants (EQ..AL, NV) and flag bit indices (N=3, Z=2, C=1, V=0).
REQ-029 One sub-module, cond_check: inputs cond[3:0], flags[3:0]; output cond_ex; purely combinational.
REQ-030 cond_logic instantiates cond_check, flag register, output gating; no other hierarchy.

Verification
REQ-031 cond=1110, pcs 0 then 1 -> pc_src 0 then 1; reg_w=1, no_write=0 -> reg_write=1; no_write=1 -> reg_write=0; mem_w=1 -> mem_write=1.
REQ-032 Per code: reset pulse, flag_w=11, cond=1110, alu_flags set, one rising edge, then cond set -> cond_ex=1 for EQ/0100, NE/0000, CS/0010, CC/0000, MI/1000, PL/0000, VS/0001, VC/0000, HI/0010, LS/0100 and 0000, GE/1001 and 0000, LT/0001 and 1000, GT/1001 and 0000, LE/0100, 0001, 1000, AL/1111.
REQ-033 Negative checks: flags=0000 -> EQ, MI, CS, VS, HI, LT give cond_ex=0; cond=1111 -> cond_ex=0, all outputs 0.
REQ-034 Group independence: flags=0000, flag_w=10, alu_flags=1111, edge -> flags=1100; then flag_w=01 -> flags=1111.
REQ-035 Gated update: flags=0000, cond=EQ, flag_w=11, alu_flags=0100, edge -> flags stay 0000 (cond_ex=0).
REQ-036 Async reset: flags=1111, reset low between edges -> flags=0000 before next edge.

Source files
------------

// File: rtl/cond_logic_pkg.sv
// Shared definitions for the conditional-execution block: condition codes
// and the bit positions of the N/Z/C/V flags within a 4-bit flag word.
package cond_logic_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder-side request bundle and gated write enables of cond_logic.
interface cond_logic_if;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic [1:0] flag_w;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;

    modport master (
        output pcs, reg_w, mem_w, no_write, flag_w, cond, alu_flags,
        input  pc_src, reg_write, mem_write
    );

    modport slave (
        input  pcs, reg_w, mem_w, no_write, flag_w, cond, alu_flags,
        output pc_src, reg_write, mem_write
    );
endinterface

// File: rtl/cond_logic_cond_check.sv
// Combinational evaluation of a 4-bit condition field against a flag word.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            EQ:      cond_ex = z;
            NE:      cond_ex = ~z;
            CS:      cond_ex = c;
            CC:      cond_ex = ~c;
            MI:      cond_ex = n;
            PL:      cond_ex = ~n;
            VS:      cond_ex = v;
            VC:      cond_ex = ~v;
            HI:      cond_ex = c & ~z;
            LS:      cond_ex = ~c | z;
            GE:      cond_ex = (n == v);
            LT:      cond_ex = (n != v);
            GT:      cond_ex = ~z & (n == v);
            LE:      cond_ex = z | (n != v);
            AL:      cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: registered N/Z/C/V flags, condition check,
// and gating of the decoder's PC, register and memory write requests.
module cond_logic
    import cond_logic_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    logic [3:0] flags;
    logic       cond_ex;
    logic [1:0] flag_write;

    cond_check u_cond_check (
        .cond    (bus.cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign flag_write = bus.flag_w & {cond_ex, cond_ex};

    // The {N,Z} and {C,V} groups update independently; each holds when not written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_write[1]) flags[N_IDX:Z_IDX] <= bus.alu_flags[N_IDX:Z_IDX];
            if (flag_write[0]) flags[C_IDX:V_IDX] <= bus.alu_flags[C_IDX:V_IDX];
        end
    end

    assign bus.pc_src    = bus.pcs & cond_ex;
    assign bus.reg_write = bus.reg_w & cond_ex & ~bus.no_write;
    assign bus.mem_write = bus.mem_w & cond_ex;

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed vector table, multi-cycle sequences and
// randomized traffic checked against a condition/flag reference model.
module tb_cond_logic;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    cond_logic_if bif ();

    cond_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flg;
        logic       exp;
    } vec_t;

    vec_t vq[$];
    logic [3:0] model_flags;

    // Each odd code is the complement of the even code below it; the AL/never pair
    // falls out of the same rule.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bif.pcs = 0; bif.reg_w = 0; bif.mem_w = 0; bif.no_write = 0;
        bif.flag_w = 2'b00; bif.cond = 4'b1110; bif.alu_flags = 4'b0000;
    endtask

    task automatic load_flags(input logic [3:0] val);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        bif.flag_w = 2'b11; bif.cond = 4'b1110; bif.alu_flags = val;
        @(posedge clk);
        #1;
        bif.flag_w = 2'b00;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        idle_inputs();
        reset = 1'b0;
        #3;
        check("reset_flags", dut.flags, 4'b0000);
        bif.pcs = 1;
        #1;
        check("reset_pc_src_al", {3'b0, bif.pc_src}, 4'b0001);
        @(posedge clk);
        #1;
        check("reset_hold_flags", dut.flags, 4'b0000);
        reset = 1'b1;

        bif.pcs = 0; #1;
        check("al_pcs0", {3'b0, bif.pc_src}, 4'b0000);
        bif.pcs = 1; #1;
        check("al_pcs1", {3'b0, bif.pc_src}, 4'b0001);
        bif.reg_w = 1; bif.no_write = 0; #1;
        check("al_reg_write", {3'b0, bif.reg_write}, 4'b0001);
        bif.no_write = 1; #1;
        check("al_no_write", {3'b0, bif.reg_write}, 4'b0000);
        bif.mem_w = 1; #1;
        check("al_mem_write", {3'b0, bif.mem_write}, 4'b0001);
        idle_inputs();

        vq.push_back('{4'b0000, 4'b0100, 1'b1});
        vq.push_back('{4'b0001, 4'b0000, 1'b1});
        vq.push_back('{4'b0010, 4'b0010, 1'b1});
        vq.push_back('{4'b0011, 4'b0000, 1'b1});
        vq.push_back('{4'b0100, 4'b1000, 1'b1});
        vq.push_back('{4'b0101, 4'b0000, 1'b1});
        vq.push_back('{4'b0110, 4'b0001, 1'b1});
        vq.push_back('{4'b0111, 4'b0000, 1'b1});
        vq.push_back('{4'b1000, 4'b0010, 1'b1});
        vq.push_back('{4'b1001, 4'b0100, 1'b1});
        vq.push_back('{4'b1001, 4'b0000, 1'b1});
        vq.push_back('{4'b1010, 4'b1001, 1'b1});
        vq.push_back('{4'b1010, 4'b0000, 1'b1});
        vq.push_back('{4'b1011, 4'b0001, 1'b1});
        vq.push_back('{4'b1011, 4'b1000, 1'b1});
        vq.push_back('{4'b1100, 4'b1001, 1'b1});
        vq.push_back('{4'b1100, 4'b0000, 1'b1});
        vq.push_back('{4'b1101, 4'b0100, 1'b1});
        vq.push_back('{4'b1101, 4'b0001, 1'b1});
        vq.push_back('{4'b1101, 4'b1000, 1'b1});
        vq.push_back('{4'b1110, 4'b1111, 1'b1});
        vq.push_back('{4'b0000, 4'b0000, 1'b0});
        vq.push_back('{4'b0100, 4'b0000, 1'b0});
        vq.push_back('{4'b0010, 4'b0000, 1'b0});
        vq.push_back('{4'b0110, 4'b0000, 1'b0});
        vq.push_back('{4'b1000, 4'b0000, 1'b0});
        vq.push_back('{4'b1011, 4'b0000, 1'b0});
        vq.push_back('{4'b1111, 4'b1111, 1'b0});
        vq.push_back('{4'b1100, 4'b0100, 1'b0});
        vq.push_back('{4'b1000, 4'b0110, 1'b0});

        for (int i = 0; i < vq.size(); i++) begin
            load_flags(vq[i].flg);
            check($sformatf("vec%0d_flags", i), dut.flags, vq[i].flg);
            bif.cond = vq[i].cond;
            bif.pcs = 1; bif.reg_w = 1; bif.mem_w = 1; bif.no_write = 0;
            #1;
            check($sformatf("vec%0d_cond_ex", i), {3'b0, dut.cond_ex}, {3'b0, vq[i].exp});
            check($sformatf("vec%0d_outs", i),
                  {1'b0, bif.pc_src, bif.reg_write, bif.mem_write}, {1'b0, {3{vq[i].exp}}});
            idle_inputs();
        end

        // Group independence
        load_flags(4'b0000);
        bif.flag_w = 2'b10; bif.cond = 4'b1110; bif.alu_flags = 4'b1111;
        @(posedge clk); #1;
        check("group_nz", dut.flags, 4'b1100);
        bif.flag_w = 2'b01;
        @(posedge clk); #1;
        check("group_cv", dut.flags, 4'b1111);
        idle_inputs();

        // Flag write gated by a failing condition
        load_flags(4'b0000);
        bif.cond = 4'b0000; bif.flag_w = 2'b11; bif.alu_flags = 4'b0100;
        #1;
        check("gated_flag_write", {2'b0, dut.flag_write}, 4'b0000);
        @(posedge clk); #1;
        check("gated_hold", dut.flags, 4'b0000);
        idle_inputs();

        // Pre-edge flags decide the write in the cycle that writes them
        load_flags(4'b0100);
        bif.cond = 4'b0000; bif.flag_w = 2'b11; bif.alu_flags = 4'b0000;
        @(posedge clk); #1;
        check("self_gate_first", dut.flags, 4'b0000);
        bif.alu_flags = 4'b1111;
        @(posedge clk); #1;
        check("self_gate_second", dut.flags, 4'b0000);
        idle_inputs();

        // Asynchronous reset between edges
        load_flags(4'b1111);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", dut.flags, 4'b0000);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", dut.flags, 4'b0000);
        bif.flag_w = 2'b11; bif.alu_flags = 4'b1010;
        @(posedge clk); #1;
        check("post_reset_first_update", dut.flags, 4'b1010);
        idle_inputs();

        reset = 1'b0; #1; reset = 1'b1;
        model_flags = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            logic exp_ex;
            logic [1:0] exp_fw;
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0; #1; reset = 1'b1;
                model_flags = 4'b0000;
            end
            bif.pcs = 1'($urandom); bif.reg_w = 1'($urandom); bif.mem_w = 1'($urandom);
            bif.no_write = 1'($urandom); bif.flag_w = 2'($urandom);
            bif.cond = 4'($urandom); bif.alu_flags = 4'($urandom);
            #1;
            exp_ex = ref_cond(bif.cond, model_flags);
            exp_fw = exp_ex ? bif.flag_w : 2'b00;
            check("rnd_cond_ex", {3'b0, dut.cond_ex}, {3'b0, exp_ex});
            check("rnd_flag_write", {2'b0, dut.flag_write}, {2'b0, exp_fw});
            check("rnd_outs", {1'b0, bif.pc_src, bif.reg_write, bif.mem_write},
                  {1'b0, bif.pcs && exp_ex, bif.reg_w && exp_ex && !bif.no_write,
                   bif.mem_w && exp_ex});
            @(posedge clk);
            if (exp_fw[1]) model_flags[3:2] = bif.alu_flags[3:2];
            if (exp_fw[0]) model_flags[1:0] = bif.alu_flags[1:0];
            #1;
            check("rnd_flags", dut.flags, model_flags);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
